stage_if_prefetch: RTL
======================

Name: stage_if_prefetch

Overview:
Parametrised instruction-fetch stage with a decoupled instruction-memory request/response interface, a prefetch queue and a valid/ready handshake to decode. It replaces the single-register fetch loop: it keeps up to DEPTH fetches in flight or buffered and supports branch redirects that flush queued and in-flight instructions. It sits between the PC-select/branch logic (redirect input) and the decode stage.

Parameters:
XLEN, 64, PC and address width
ILEN, 32, instruction width
DEPTH, 4, prefetch queue entries and maximum in-flight plus buffered fetches (power of two, >=2)
RESET_PC, 0, fetch address after reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  branch taken / redirect this cycle
redirect_target  in  XLEN  new fetch address; bits [1:0] forced to 0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_rsp_valid  in  1  response data valid; responses return in request order, >=1 cycle after acceptance
imem_rsp_data  in  ILEN  fetched instruction
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts instruction
out_pc  out  XLEN  PC of presented instruction
out_instr  out  ILEN  presented instruction

Behaviour:
- Registers: req_pc (next address to request), rsp_pc (PC of the next accepted response), inflight count, drop count, queue of {pc, instr}.
- Reset: req_pc=rsp_pc=RESET_PC, inflight=0, drop=0, queue empty; out_valid=0, imem_req_valid=0 during and in the cycle reset is asserted. Reset mid-operation discards everything; responses to pre-reset requests are not tracked (the memory is reset together with this block).
- Request: imem_req_valid = !reset && !redirect_valid && (inflight + queue_count) < DEPTH. imem_req_addr = req_pc. On valid&&ready: req_pc += PC_STEP (wraps modulo 2^XLEN), inflight++.
- Response: on imem_rsp_valid with inflight>0: inflight--. If drop>0, decrement drop and discard. Otherwise push {rsp_pc, imem_rsp_data} and rsp_pc += PC_STEP. A response with inflight==0 is a protocol error and is ignored.
- Output: out_valid = queue non-empty; out_pc/out_instr = head. Pop on out_valid&&out_ready. Minimum latency: request accepted in cycle N, response in N+1, out_valid in N+2.
- Redirect (highest priority): in the same cycle no request is issued. Next state: req_pc=rsp_pc=target&~3, queue emptied, drop = inflight after this cycle's response accounting (a same-cycle response is itself discarded), out_valid=0. A same-cycle out handshake counts as consumed; decode squashes it.
- Credit rule: inflight+queue_count <= DEPTH at all times, so the queue never overflows and responses never need backpressure. Push and pop in the same cycle are legal, including when the queue is full or empty (empty: push then pop next cycle, no bypass).
- Back-to-back redirects: each one re-targets; drop accumulates correctly because inflight never increases during a redirect cycle.
- Counter widths: $clog2(DEPTH+1) bits.

Decomposition:
- Package if_pkg: default widths, PC_STEP, RESET_PC, fetch-entry struct {pc, instr}.
- One sub-module: fetch_fifo (synchronous FIFO, parameters WIDTH, DEPTH; ports push, pop, flush, din, dout, count, empty, full; flush beats push).

Test Plan:
- Reset then stream with imem_req_ready=1, 1-cycle response, out_ready=1 -> out_pc 0x0,0x4,0x8,... one per cycle from cycle 3; out_instr matches memory image.
- out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued (0x0..0xC), then imem_req_valid=0; releasing out_ready drains 0x0..0xC in order with no loss.
- Redirect to 0x1000 with 2 fetches in flight (3-cycle memory latency) -> both responses discarded; the first out_pc after redirect is 0x1000 and no 0x8/0xC appears.
- Redirect to 0x2002 in the same cycle a response arrives -> response dropped, no request that cycle, next imem_req_addr=0x2000.
- imem_req_ready toggling 1/0 with random response delay 1-4 -> out_pc strictly sequential by PC_STEP, inflight+count never exceeds DEPTH.
- Reset asserted mid-stream with a full queue -> next cycle out_valid=0, imem_req_valid=0; after release, first request address=RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared defaults and the fetch-entry record for the instruction-fetch prefetch stage.
package if_pkg;

  localparam int unsigned IF_XLEN     = 64;
  localparam int unsigned IF_ILEN     = 32;
  localparam int unsigned IF_DEPTH    = 4;
  localparam int unsigned IF_PC_STEP  = 4;
  localparam logic [IF_XLEN-1:0] IF_RESET_PC = '0;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/stage_if_prefetch_if.sv
// Instruction-memory request/response channel plus the fetch-to-decode handshake.
interface stage_if_prefetch_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush wins over a same-cycle push.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/stage_if_prefetch.sv
// Instruction-fetch stage: credit-limited request issue, in-order response capture into a
// prefetch queue, and redirects that flush buffered entries and drop in-flight responses.
module stage_if_prefetch
  import if_pkg::*;
#(
  parameter int              XLEN     = IF_XLEN,
  parameter int              ILEN     = IF_ILEN,
  parameter int              DEPTH    = IF_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IF_RESET_PC),
  parameter int              PC_STEP  = IF_PC_STEP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_target,
  stage_if_prefetch_if.master bus
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [XLEN-1:0] req_pc_nx;
  logic [XLEN-1:0] rsp_pc_nx;
  logic [CW-1:0]   inflight_nx;
  logic [CW-1:0]   drop_nx;

  logic [CW-1:0]   q_count;
  logic            q_empty;
  logic            q_full;
  entry_t          q_din;
  entry_t          q_dout;

  logic [OW-1:0]   occupancy;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_take;
  logic            rsp_drop;
  logic            push_q;
  logic            out_valid;
  logic            pop_q;
  logic [XLEN-1:0] target_aligned;

  // Request side: one credit per queue slot covers both in-flight and buffered fetches.
  assign occupancy = {1'b0, inflight} + {1'b0, q_count};
  assign req_valid = !reset && !redirect_valid && (occupancy < OW'(DEPTH));
  assign req_fire  = req_valid && bus.imem_req_ready;

  // Response side: responses with nothing outstanding are stray and ignored.
  assign rsp_take  = bus.imem_rsp_valid && (inflight != '0);
  assign rsp_drop  = rsp_take && (drop != '0);
  assign push_q    = rsp_take && !rsp_drop;
  assign q_din     = '{pc: rsp_pc, instr: bus.imem_rsp_data};

  assign out_valid = !reset && !q_empty;
  assign pop_q     = out_valid && bus.out_ready;

  assign target_aligned = {redirect_target[XLEN-1:2], 2'b00};

  always_comb begin
    inflight_nx = inflight + CW'(req_fire) - CW'(rsp_take);
    drop_nx     = drop - CW'(rsp_drop);
    req_pc_nx   = req_fire ? req_pc + XLEN'(PC_STEP) : req_pc;
    rsp_pc_nx   = push_q ? rsp_pc + XLEN'(PC_STEP) : rsp_pc;
    // No request issues during a redirect, so every remaining in-flight fetch is stale.
    if (redirect_valid) begin
      req_pc_nx = target_aligned;
      rsp_pc_nx = target_aligned;
      drop_nx   = inflight_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_pc   <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      req_pc   <= req_pc_nx;
      rsp_pc   <= rsp_pc_nx;
      inflight <= inflight_nx;
      drop     <= drop_nx;
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .pop   (pop_q),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_pc;
  assign bus.out_valid      = out_valid;
  assign bus.out_pc         = q_dout.pc;
  assign bus.out_instr      = q_dout.instr;

endmodule
